// File: rtl/pipeline_control_irq_dispatch_pkg.sv
// Shared pipeline-control definitions: dispatch FSM encodings and handler alignment helper.
package pipeline_control_irq_dispatch_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRAIN   = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    JUMP    = 3'd4
  } irq_state_t;

  localparam int unsigned IRQ_NUM_W = 7;
  localparam int unsigned ADDR_W    = 32;

  function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr);
    return |addr[1:0];
  endfunction

endpackage

// File: rtl/pipeline_control_irq_dispatch.sv
// Interrupt entry sequencer: accept one IRQ, drain the pipeline, fetch the handler
// address through the IDT read stage, then issue a single held jump request.
//
// state   | meaning
// IDLE    | waiting for an enabled pending interrupt
// DRAIN   | pipeline stop requested, waiting for empty; captures resume PC
// RD_REQ  | one-cycle handler-read start
// RD_WAIT | waiting for handler-read finish; captures handler and fault
// JUMP    | jump request held until acknowledged
module pipeline_control_irq_dispatch
  import pipeline_control_irq_dispatch_pkg::*;
(
  input  logic                 iCLOCK,
  input  logic                 inRESET,
  input  logic                 iRESET_SYNC,
  input  logic                 iIRQ_VALID,
  input  logic [IRQ_NUM_W-1:0] iIRQ_NUM,
  output logic                 oIRQ_ACK,
  input  logic                 iIRQ_ENA,
  output logic                 oPIPE_STOP,
  input  logic                 iPIPE_EMPTY,
  input  logic [ADDR_W-1:0]    iCURRENT_PC,
  output logic                 oRD_START,
  output logic [IRQ_NUM_W-1:0] oRD_IRQ_NUM,
  input  logic                 iRD_FINISH,
  input  logic [ADDR_W-1:0]    iRD_HUNDLER,
  output logic                 oJUMP_VALID,
  output logic [ADDR_W-1:0]    oJUMP_ADDR,
  input  logic                 iJUMP_ACK,
  output logic [ADDR_W-1:0]    oSAVE_PC,
  output logic [IRQ_NUM_W-1:0] oSAVE_IRQ_NUM,
  output logic                 oHUNDLER_FAULT,
  output logic                 oBUSY
);

  irq_state_t             state_q, state_d;
  logic [IRQ_NUM_W-1:0]   irq_num_q;
  logic [ADDR_W-1:0]      save_pc_q;
  logic [ADDR_W-1:0]      handler_q;
  logic                   fault_q;
  logic                   accept;

  // Reset gating keeps the combinational ack low while either reset is active.
  assign accept = (state_q == IDLE) && iIRQ_VALID && iIRQ_ENA && inRESET && !iRESET_SYNC;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)      state_d = DRAIN;
      DRAIN:   if (iPIPE_EMPTY) state_d = RD_REQ;
      RD_REQ:                   state_d = RD_WAIT;
      RD_WAIT: if (iRD_FINISH)  state_d = JUMP;
      JUMP:    if (iJUMP_ACK)   state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_q   <= IDLE;
      irq_num_q <= '0;
      save_pc_q <= '0;
      handler_q <= '0;
      fault_q   <= 1'b0;
    end else if (iRESET_SYNC) begin
      state_q   <= IDLE;
      irq_num_q <= '0;
      save_pc_q <= '0;
      handler_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) irq_num_q <= iIRQ_NUM;
      if (state_q == DRAIN && iPIPE_EMPTY) save_pc_q <= iCURRENT_PC;
      if (state_q == RD_WAIT && iRD_FINISH) begin
        handler_q <= iRD_HUNDLER;
        fault_q   <= is_misaligned(iRD_HUNDLER);
      end
    end
  end

  assign oIRQ_ACK       = accept;
  assign oPIPE_STOP     = (state_q != IDLE);
  assign oBUSY          = (state_q != IDLE);
  assign oRD_START      = (state_q == RD_REQ);
  assign oRD_IRQ_NUM    = irq_num_q;
  assign oSAVE_IRQ_NUM  = irq_num_q;
  assign oJUMP_VALID    = (state_q == JUMP);
  assign oJUMP_ADDR     = handler_q;
  assign oSAVE_PC       = save_pc_q;
  assign oHUNDLER_FAULT = fault_q;

endmodule

// File: tb/tb_pipeline_control_irq_dispatch.sv
// Directed bench for the interrupt entry sequencer; inputs change 1ns after the
// rising edge, outputs are checked on the falling edge.
module tb_pipeline_control_irq_dispatch;

  logic        iCLOCK = 1'b0;
  logic        inRESET;
  logic        iRESET_SYNC;
  logic        iIRQ_VALID;
  logic [6:0]  iIRQ_NUM;
  logic        oIRQ_ACK;
  logic        iIRQ_ENA;
  logic        oPIPE_STOP;
  logic        iPIPE_EMPTY;
  logic [31:0] iCURRENT_PC;
  logic        oRD_START;
  logic [6:0]  oRD_IRQ_NUM;
  logic        iRD_FINISH;
  logic [31:0] iRD_HUNDLER;
  logic        oJUMP_VALID;
  logic [31:0] oJUMP_ADDR;
  logic        iJUMP_ACK;
  logic [31:0] oSAVE_PC;
  logic [6:0]  oSAVE_IRQ_NUM;
  logic        oHUNDLER_FAULT;
  logic        oBUSY;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 iCLOCK = ~iCLOCK;

  pipeline_control_irq_dispatch dut (
    .iCLOCK        (iCLOCK),
    .inRESET       (inRESET),
    .iRESET_SYNC   (iRESET_SYNC),
    .iIRQ_VALID    (iIRQ_VALID),
    .iIRQ_NUM      (iIRQ_NUM),
    .oIRQ_ACK      (oIRQ_ACK),
    .iIRQ_ENA      (iIRQ_ENA),
    .oPIPE_STOP    (oPIPE_STOP),
    .iPIPE_EMPTY   (iPIPE_EMPTY),
    .iCURRENT_PC   (iCURRENT_PC),
    .oRD_START     (oRD_START),
    .oRD_IRQ_NUM   (oRD_IRQ_NUM),
    .iRD_FINISH    (iRD_FINISH),
    .iRD_HUNDLER   (iRD_HUNDLER),
    .oJUMP_VALID   (oJUMP_VALID),
    .oJUMP_ADDR    (oJUMP_ADDR),
    .iJUMP_ACK     (iJUMP_ACK),
    .oSAVE_PC      (oSAVE_PC),
    .oSAVE_IRQ_NUM (oSAVE_IRQ_NUM),
    .oHUNDLER_FAULT(oHUNDLER_FAULT),
    .oBUSY         (oBUSY)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic sample();
    @(negedge iCLOCK);
  endtask

  task automatic tick();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ack"},   oIRQ_ACK,    0);
    check({tag, "_stop"},  oPIPE_STOP,  0);
    check({tag, "_busy"},  oBUSY,       0);
    check({tag, "_start"}, oRD_START,   0);
    check({tag, "_jump"},  oJUMP_VALID, 0);
  endtask

  initial begin
    repeat (2000) @(posedge iCLOCK);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    inRESET = 1'b0; iRESET_SYNC = 1'b0;
    iIRQ_VALID = 1'b1; iIRQ_ENA = 1'b1; iIRQ_NUM = 7'h44;
    iPIPE_EMPTY = 1'b0; iCURRENT_PC = '0;
    iRD_FINISH = 1'b0; iRD_HUNDLER = '0; iJUMP_ACK = 1'b0;

    // Async reset with a pending interrupt: everything must stay 0.
    sample();
    check_idle_outputs("rst");
    check("rst_num",   oRD_IRQ_NUM,    0);
    check("rst_pc",    oSAVE_PC,       0);
    check("rst_addr",  oJUMP_ADDR,     0);
    check("rst_fault", oHUNDLER_FAULT, 0);
    tick();
    iIRQ_VALID = 1'b0; iIRQ_ENA = 1'b0; iIRQ_NUM = '0;
    inRESET = 1'b1;
    tick();

    // Basic entry, IRQ 0x05, spurious finish in DRAIN, number changes after ack.
    iIRQ_VALID = 1'b1; iIRQ_ENA = 1'b1; iIRQ_NUM = 7'h05;
    sample();
    check("b_ack", oIRQ_ACK, 1);
    check("b_busy0", oBUSY, 0);
    tick();
    iIRQ_VALID = 1'b0; iIRQ_NUM = 7'h7F;
    iRD_FINISH = 1'b1; iRD_HUNDLER = 32'hDEAD_BEEF;
    sample();
    check("b_ack_pulse", oIRQ_ACK, 0);
    check("b_stop", oPIPE_STOP, 1);
    check("b_busy", oBUSY, 1);
    check("b_num_stable", oRD_IRQ_NUM, 32'h05);
    tick();
    iRD_FINISH = 1'b0; iRD_HUNDLER = '0;
    tick();
    tick();
    iPIPE_EMPTY = 1'b1; iCURRENT_PC = 32'h0000_1000;
    sample();
    check("b_nostart_drain", oRD_START, 0);
    tick();
    iPIPE_EMPTY = 1'b0; iCURRENT_PC = 32'h0BAD_0000;
    sample();
    check("b_start", oRD_START, 1);
    check("b_rd_num", oRD_IRQ_NUM, 32'h05);
    check("b_nojump", oJUMP_VALID, 0);
    tick();
    sample();
    check("b_start_once", oRD_START, 0);
    check("b_spurious_ignored", oJUMP_VALID, 0);
    iRD_FINISH = 1'b1; iRD_HUNDLER = 32'h0000_8000;
    tick();
    iRD_FINISH = 1'b0; iRD_HUNDLER = '0; iJUMP_ACK = 1'b1;
    sample();
    check("b_jump", oJUMP_VALID, 1);
    check("b_addr", oJUMP_ADDR, 32'h0000_8000);
    check("b_save_pc", oSAVE_PC, 32'h0000_1000);
    check("b_save_num", oSAVE_IRQ_NUM, 32'h05);
    check("b_fault", oHUNDLER_FAULT, 0);
    tick();
    iJUMP_ACK = 1'b0;
    sample();
    check_idle_outputs("b_done");

    // Disabled for 10 cycles, then enable acks in the same cycle.
    tick();
    iIRQ_VALID = 1'b1; iIRQ_ENA = 1'b0; iIRQ_NUM = 7'h22;
    for (int i = 0; i < 10; i++) begin
      sample();
      check("d_noack", oIRQ_ACK, 0);
      check("d_busy", oBUSY, 0);
      check("d_stop", oPIPE_STOP, 0);
      tick();
    end
    iIRQ_ENA = 1'b1;
    sample();
    check("d_ack", oIRQ_ACK, 1);
    tick();
    iIRQ_VALID = 1'b0; iIRQ_ENA = 1'b0;
    iPIPE_EMPTY = 1'b1; iCURRENT_PC = 32'h0000_2000;
    tick();
    iPIPE_EMPTY = 1'b0;
    sample();
    check("d_start", oRD_START, 1);
    check("d_num", oRD_IRQ_NUM, 32'h22);
    tick();
    iRD_FINISH = 1'b1; iRD_HUNDLER = 32'h0000_8002;
    tick();
    iRD_FINISH = 1'b0; iRD_HUNDLER = '0;

    // Misaligned handler with back-pressure on the jump ack.
    for (int i = 0; i < 6; i++) begin
      sample();
      check("f_jump_held", oJUMP_VALID, 1);
      check("f_fault", oHUNDLER_FAULT, 1);
      tick();
    end
    iJUMP_ACK = 1'b1;
    sample();
    check("f_jump_last", oJUMP_VALID, 1);
    check("f_addr", oJUMP_ADDR, 32'h0000_8002);
    check("f_pc", oSAVE_PC, 32'h0000_2000);
    tick();
    iJUMP_ACK = 1'b0;
    sample();
    check("f_idle", oBUSY, 0);
    check("f_jump_off", oJUMP_VALID, 0);

    // Sync reset in RD_WAIT, coincident with finish: reset wins.
    tick();
    iIRQ_VALID = 1'b1; iIRQ_ENA = 1'b1; iIRQ_NUM = 7'h33;
    tick();
    iIRQ_VALID = 1'b0; iPIPE_EMPTY = 1'b1; iCURRENT_PC = 32'h0000_3000;
    tick();
    iPIPE_EMPTY = 1'b0;
    tick();
    iRESET_SYNC = 1'b1; iRD_FINISH = 1'b1; iRD_HUNDLER = 32'h0000_A000;
    sample();
    check("r_in_wait", oBUSY, 1);
    tick();
    iRESET_SYNC = 1'b0;
    sample();
    check_idle_outputs("r_after");
    check("r_num", oRD_IRQ_NUM, 0);
    check("r_pc", oSAVE_PC, 0);
    check("r_addr", oJUMP_ADDR, 0);
    tick();
    sample();
    check("r_late_finish", oJUMP_VALID, 0);
    check("r_late_busy", oBUSY, 0);
    tick();
    iRD_FINISH = 1'b0; iRD_HUNDLER = '0;

    // Back-to-back: valid held, ack in the first JUMP cycle.
    iIRQ_VALID = 1'b1; iIRQ_ENA = 1'b1; iIRQ_NUM = 7'h11;
    sample();
    check("bb_ack1", oIRQ_ACK, 1);
    tick();
    iIRQ_NUM = 7'h12; iPIPE_EMPTY = 1'b1; iCURRENT_PC = 32'h0000_4000;
    sample();
    check("bb_noack_drain", oIRQ_ACK, 0);
    tick();
    iPIPE_EMPTY = 1'b0;
    tick();
    iRD_FINISH = 1'b1; iRD_HUNDLER = 32'h0000_9000;
    tick();
    iRD_FINISH = 1'b0; iJUMP_ACK = 1'b1;
    sample();
    check("bb_jump", oJUMP_VALID, 1);
    check("bb_noack_jump", oIRQ_ACK, 0);
    check("bb_num1", oSAVE_IRQ_NUM, 32'h11);
    tick();
    iJUMP_ACK = 1'b0;
    sample();
    check("bb_ack2", oIRQ_ACK, 1);
    check("bb_idle", oBUSY, 0);
    tick();
    iIRQ_VALID = 1'b0;
    sample();
    check("bb_busy2", oBUSY, 1);
    check("bb_num2", oRD_IRQ_NUM, 32'h12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
